// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle: stage controls, ID-side fields, EX-side registered
// copies and the bubble/flush event counters.
interface id_ex_stage_reg_if;
  // Stage controls
  logic        freeze;
  logic        flush;
  logic        hazard;

  // ID side
  logic        id_valid;
  logic        WB_EN_in;
  logic        MEM_R_EN_in;
  logic        MEM_W_EN_in;
  logic        B_in;
  logic        S_in;
  logic [3:0]  EXE_CMD_in;
  logic [31:0] PC_in;
  logic [31:0] Val_Rn_in;
  logic [31:0] Val_Rm_in;
  logic        imm_in;
  logic [11:0] Shift_operand_in;
  logic [23:0] Signed_imm_24_in;
  logic [3:0]  Dest_in;
  logic [3:0]  src1_in;
  logic [3:0]  src2_in;
  logic [3:0]  SR_in;

  // EX side
  logic        valid_out;
  logic        WB_EN_out;
  logic        MEM_R_EN_out;
  logic        MEM_W_EN_out;
  logic        B_out;
  logic        S_out;
  logic [3:0]  EXE_CMD_out;
  logic [31:0] PC_out;
  logic [31:0] Val_Rn_out;
  logic [31:0] Val_Rm_out;
  logic        imm_out;
  logic [11:0] Shift_operand_out;
  logic [23:0] Signed_imm_24_out;
  logic [3:0]  Dest_out;
  logic [3:0]  src1_out;
  logic [3:0]  src2_out;
  logic [3:0]  SR_out;

  // Event counters
  logic [15:0] bubble_cnt;
  logic [15:0] flush_cnt;

  // Decode/pipeline-control side: drives ID fields and controls.
  modport master (
    output freeze, flush, hazard,
    output id_valid, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, EXE_CMD_in,
    output PC_in, Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in, Signed_imm_24_in,
    output Dest_in, src1_in, src2_in, SR_in,
    input  valid_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, EXE_CMD_out,
    input  PC_out, Val_Rn_out, Val_Rm_out, imm_out, Shift_operand_out, Signed_imm_24_out,
    input  Dest_out, src1_out, src2_out, SR_out,
    input  bubble_cnt, flush_cnt
  );

  // Pipeline register side.
  modport slave (
    input  freeze, flush, hazard,
    input  id_valid, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, EXE_CMD_in,
    input  PC_in, Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in, Signed_imm_24_in,
    input  Dest_in, src1_in, src2_in, SR_in,
    output valid_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, EXE_CMD_out,
    output PC_out, Val_Rn_out, Val_Rm_out, imm_out, Shift_operand_out, Signed_imm_24_out,
    output Dest_out, src1_out, src2_out, SR_out,
    output bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register. One action per edge, priority
// freeze > flush > hazard > load. Flush and hazard both load an all-zero
// bubble; a load with id_valid=0 keeps the datapath but clears side effects.
module id_ex_stage_reg (
  input  logic              clk,
  input  logic              rst,
  id_ex_stage_reg_if.slave  bus
);

  typedef struct packed {
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        b;
    logic        s;
    logic [3:0]  exe_cmd;
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  sr;
  } stage_t;

  stage_t      load_d;
  stage_t      stage_q;
  logic        valid_q;
  logic [15:0] bubble_q;
  logic [15:0] flush_q;
  logic        kill;

  // Flush and hazard share the same bubble result.
  assign kill = bus.flush | bus.hazard;

  // Capture ID fields; an invalid slot must not write back, touch memory,
  // branch or update flags.
  always_comb begin
    // NOTE: every field is assigned on every path, so no latch is inferred.
    load_d               = '0;
    load_d.wb_en         = bus.WB_EN_in    & bus.id_valid;
    load_d.mem_r_en      = bus.MEM_R_EN_in & bus.id_valid;
    load_d.mem_w_en      = bus.MEM_W_EN_in & bus.id_valid;
    load_d.b             = bus.B_in        & bus.id_valid;
    load_d.s             = bus.S_in        & bus.id_valid;
    load_d.exe_cmd       = bus.EXE_CMD_in;
    load_d.pc            = bus.PC_in;
    load_d.val_rn        = bus.Val_Rn_in;
    load_d.val_rm        = bus.Val_Rm_in;
    load_d.imm           = bus.imm_in;
    load_d.shift_operand = bus.Shift_operand_in;
    load_d.signed_imm_24 = bus.Signed_imm_24_in;
    load_d.dest          = bus.Dest_in;
    load_d.src1          = bus.src1_in;
    load_d.src2          = bus.src2_in;
    load_d.sr            = bus.SR_in;
  end

  // Stage register: hold, bubble or load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
      valid_q <= 1'b0;
    end else if (bus.freeze) begin
      // NOTE: non-blocking assignment keeps every register sampling pre-edge values.
      stage_q <= stage_q;
      valid_q <= valid_q;
    end else if (kill) begin
      stage_q <= '0;
      valid_q <= 1'b0;
    end else begin
      stage_q <= load_d;
      valid_q <= bus.id_valid;
    end
  end

  // Saturating event counters; a combined flush+hazard counts only as a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_q <= '0;
      flush_q  <= '0;
    end else if (!bus.freeze) begin
      if (bus.flush) begin
        if (bus.id_valid && flush_q != 16'hFFFF)
          flush_q <= flush_q + 16'd1;
      end else if (bus.hazard) begin
        if (bubble_q != 16'hFFFF)
          bubble_q <= bubble_q + 16'd1;
      end
    end
  end

  assign bus.valid_out         = valid_q;
  assign bus.WB_EN_out         = stage_q.wb_en;
  assign bus.MEM_R_EN_out      = stage_q.mem_r_en;
  assign bus.MEM_W_EN_out      = stage_q.mem_w_en;
  assign bus.B_out             = stage_q.b;
  assign bus.S_out             = stage_q.s;
  assign bus.EXE_CMD_out       = stage_q.exe_cmd;
  assign bus.PC_out            = stage_q.pc;
  assign bus.Val_Rn_out        = stage_q.val_rn;
  assign bus.Val_Rm_out        = stage_q.val_rm;
  assign bus.imm_out           = stage_q.imm;
  assign bus.Shift_operand_out = stage_q.shift_operand;
  assign bus.Signed_imm_24_out = stage_q.signed_imm_24;
  assign bus.Dest_out          = stage_q.dest;
  assign bus.src1_out          = stage_q.src1;
  assign bus.src2_out          = stage_q.src2;
  assign bus.SR_out            = stage_q.sr;
  assign bus.bubble_cnt        = bubble_q;
  assign bus.flush_cnt         = flush_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: load, invalid load, freeze priority,
// flush, hazard bubbles, combined requests, async reset and saturation.
`timescale 1ns/1ps
module tb_id_ex_stage_reg;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  id_ex_stage_reg_if bus ();

  id_ex_stage_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.freeze = 0; bus.flush = 0; bus.hazard = 0;
    bus.id_valid = 0; bus.WB_EN_in = 0; bus.MEM_R_EN_in = 0; bus.MEM_W_EN_in = 0;
    bus.B_in = 0; bus.S_in = 0; bus.EXE_CMD_in = 0; bus.PC_in = 0;
    bus.Val_Rn_in = 0; bus.Val_Rm_in = 0; bus.imm_in = 0; bus.Shift_operand_in = 0;
    bus.Signed_imm_24_in = 0; bus.Dest_in = 0; bus.src1_in = 0; bus.src2_in = 0;
    bus.SR_in = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},  {31'd0, bus.valid_out}, 32'd0);
    check({tag, "_ctrl"},   {27'd0, bus.WB_EN_out, bus.MEM_R_EN_out, bus.MEM_W_EN_out,
                             bus.B_out, bus.S_out}, 32'd0);
    check({tag, "_pc"},     bus.PC_out, 32'd0);
    check({tag, "_rn"},     bus.Val_Rn_out, 32'd0);
    check({tag, "_dest"},   {28'd0, bus.Dest_out}, 32'd0);
    check({tag, "_cmd"},    {28'd0, bus.EXE_CMD_out}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    rst = 1'b1;

    // Reset holds everything at zero even with nonzero inputs and freeze.
    #3;
    check_zero("rst0");
    check("rst0_bub", {16'd0, bus.bubble_cnt}, 32'd0);
    check("rst0_fl",  {16'd0, bus.flush_cnt}, 32'd0);
    bus.id_valid = 1; bus.WB_EN_in = 1; bus.PC_in = 32'h1234; bus.freeze = 1;
    step();
    check_zero("rst1");
    rst = 1'b0;
    clear_inputs();

    // Plain load, one-cycle latency.
    bus.id_valid = 1; bus.WB_EN_in = 1; bus.Dest_in = 4'h3;
    bus.Val_Rn_in = 32'hDEADBEEF; bus.PC_in = 32'h40;
    step();
    check("ld_wb",    {31'd0, bus.WB_EN_out}, 32'd1);
    check("ld_dest",  {28'd0, bus.Dest_out}, 32'd3);
    check("ld_rn",    bus.Val_Rn_out, 32'hDEADBEEF);
    check("ld_valid", {31'd0, bus.valid_out}, 32'd1);
    check("ld_pc",    bus.PC_out, 32'h40);

    // Load with id_valid=0: side effects cleared, datapath captured.
    bus.id_valid = 0; bus.WB_EN_in = 1; bus.MEM_R_EN_in = 1; bus.MEM_W_EN_in = 1;
    bus.B_in = 1; bus.S_in = 1; bus.Val_Rm_in = 32'h1234; bus.PC_in = 32'h44;
    bus.EXE_CMD_in = 4'h5;
    step();
    check("inv_ctrl",  {27'd0, bus.WB_EN_out, bus.MEM_R_EN_out, bus.MEM_W_EN_out,
                        bus.B_out, bus.S_out}, 32'd0);
    check("inv_valid", {31'd0, bus.valid_out}, 32'd0);
    check("inv_rm",    bus.Val_Rm_out, 32'h1234);
    check("inv_pc",    bus.PC_out, 32'h44);
    check("inv_cmd",   {28'd0, bus.EXE_CMD_out}, 32'd5);

    // Valid load exercising the remaining fields.
    clear_inputs();
    bus.id_valid = 1; bus.PC_in = 32'h40; bus.SR_in = 4'hA; bus.src1_in = 4'h1;
    bus.src2_in = 4'h2; bus.imm_in = 1; bus.Shift_operand_in = 12'hABC;
    bus.Signed_imm_24_in = 24'h123456; bus.MEM_R_EN_in = 1; bus.S_in = 1;
    step();
    check("fld_sr",   {28'd0, bus.SR_out}, 32'hA);
    check("fld_src",  {24'd0, bus.src1_out, bus.src2_out}, 32'h12);
    check("fld_imm",  {31'd0, bus.imm_out}, 32'd1);
    check("fld_sh",   {20'd0, bus.Shift_operand_out}, 32'hABC);
    check("fld_si",   {8'd0, bus.Signed_imm_24_out}, 32'h123456);
    check("fld_ctrl", {27'd0, bus.WB_EN_out, bus.MEM_R_EN_out, bus.MEM_W_EN_out,
                       bus.B_out, bus.S_out}, 32'b01001);

    // Freeze beats flush; flush lands once freeze drops.
    bus.freeze = 1; bus.flush = 1; bus.PC_in = 32'h80;
    step();
    step();
    check("frz_pc",    bus.PC_out, 32'h40);
    check("frz_valid", {31'd0, bus.valid_out}, 32'd1);
    check("frz_fl",    {16'd0, bus.flush_cnt}, 32'd0);
    bus.freeze = 0;
    step();
    check_zero("fl");
    check("fl_cnt",  {16'd0, bus.flush_cnt}, 32'd1);
    check("fl_bub",  {16'd0, bus.bubble_cnt}, 32'd0);

    // Two hazard bubbles.
    bus.flush = 0; bus.hazard = 1; bus.MEM_W_EN_in = 1;
    step();
    check("hz1_valid", {31'd0, bus.valid_out}, 32'd0);
    check("hz1_mw",    {31'd0, bus.MEM_W_EN_out}, 32'd0);
    step();
    check("hz2_mw",    {31'd0, bus.MEM_W_EN_out}, 32'd0);
    check("hz2_bub",   {16'd0, bus.bubble_cnt}, 32'd2);

    // Flush and hazard together count as a flush only.
    bus.flush = 1; bus.WB_EN_in = 1; bus.B_in = 1;
    step();
    check_zero("fh");
    check("fh_fl",  {16'd0, bus.flush_cnt}, 32'd2);
    check("fh_bub", {16'd0, bus.bubble_cnt}, 32'd2);

    // Flushing an invalid slot is not counted.
    bus.hazard = 0; bus.id_valid = 0;
    step();
    check("fli_fl", {16'd0, bus.flush_cnt}, 32'd2);

    // Hazard deferred by freeze.
    clear_inputs();
    bus.id_valid = 1; bus.PC_in = 32'h50;
    step();
    bus.freeze = 1; bus.hazard = 1;
    step();
    check("fh_hold_valid", {31'd0, bus.valid_out}, 32'd1);
    check("fh_hold_bub",   {16'd0, bus.bubble_cnt}, 32'd2);
    bus.freeze = 0;
    step();
    check("fh_rel_valid", {31'd0, bus.valid_out}, 32'd0);
    check("fh_rel_bub",   {16'd0, bus.bubble_cnt}, 32'd3);

    // Async reset between edges while outputs are nonzero.
    clear_inputs();
    bus.id_valid = 1; bus.PC_in = 32'h40; bus.Val_Rn_in = 32'h55; bus.Dest_in = 4'h7;
    bus.EXE_CMD_in = 4'h9; bus.WB_EN_in = 1;
    step();
    check("pre_rst_pc", bus.PC_out, 32'h40);
    bus.freeze = 1;
    #2;
    rst = 1'b1;
    #1;
    check_zero("arst");
    check("arst_bub", {16'd0, bus.bubble_cnt}, 32'd0);
    check("arst_fl",  {16'd0, bus.flush_cnt}, 32'd0);
    step();
    check_zero("arst_hold");
    rst = 1'b0;
    clear_inputs();

    // Saturation of bubble_cnt.
    bus.hazard = 1;
    for (int i = 0; i < 65535; i++) @(posedge clk);
    #1;
    check("sat_full", {16'd0, bus.bubble_cnt}, 32'hFFFF);
    step();
    check("sat_hold", {16'd0, bus.bubble_cnt}, 32'hFFFF);
    check("sat_fl",   {16'd0, bus.flush_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-002 SHALL have control inputs: freeze  in  1  memory-stall hold; flush  in  1  taken-branch kill; hazard  in  1  hazard-detector bubble request.
REQ-003 SHALL have ID-side inputs:
- id_valid 1; WB_EN_in 1; MEM_R_EN_in 1; MEM_W_EN_in 1; B_in 1; S_in 1; EXE_CMD_in 4
- PC_in 32; Val_Rn_in 32; Val_Rm_in 32; imm_in 1; Shift_operand_in 12; Signed_imm_24_in 24
- Dest_in 4; src1_in 4; src2_in 4; SR_in 4 (status flags N,Z,C,V)
REQ-004 SHALL have EX-side outputs: registered same-named copies with suffix _out, plus valid_out 1.
REQ-005 SHALL have bubble_cnt  out  16: count of cycles a bubble was inserted because of hazard.
REQ-006 SHALL have flush_cnt  out  16: count of cycles a valid instruction was killed because of flush.

Function
REQ-007 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-008 Per rising edge, exactly one action SHALL apply, chosen by priority: freeze > flush > hazard > load.
REQ-009 Freeze: all _out registers, valid_out and both counters SHALL hold their values.
REQ-010 Flush (freeze=0): valid_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out and S_out SHALL become 0; EXE_CMD_out and Dest_out SHALL become 0; datapath fields SHALL become 0.
REQ-011 Hazard (freeze=0, flush=0): the register SHALL load a bubble identical to a flush result, so that no write-back, memory access, branch or status update occurs in EX.
REQ-012 Load (freeze=0, flush=0, hazard=0): every _out SHALL take its _in value; valid_out SHALL take id_valid.
REQ-013 Load with id_valid=0: control bits (WB_EN, MEM_R_EN, MEM_W_EN, B, S) SHALL be forced to 0; datapath fields SHALL still be captured.
REQ-014 Latency SHALL be exactly one cycle from ID inputs to EX outputs when no freeze, flush or hazard is asserted.
REQ-015 bubble_cnt SHALL increment by 1 on each edge where the hazard action is taken.
REQ-016 flush_cnt SHALL increment by 1 on each edge where the flush action is taken and id_valid=1.
REQ-017 Both counters SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-018 Dest_out, WB_EN_out and MEM_R_EN_out SHALL be directly usable by the downstream hazard detector as its EX-destination, EX write-enable and EX memory-read-enable inputs.
REQ-019 src1_out and src2_out SHALL be directly usable by the forwarding unit.
REQ-020 If flush and hazard are asserted together with freeze=0, the flush action SHALL be taken; only flush_cnt SHALL be eligible to increment, and bubble_cnt SHALL hold.
REQ-021 If freeze is asserted together with flush and/or hazard, all state SHALL hold; the flush or hazard action SHALL take effect on the first edge after freeze deasserts, provided the request is still asserted.

Reset
REQ-022 While rst=1, asynchronously and independent of clk, every output including valid_out, bubble_cnt and flush_cnt SHALL be 0.
REQ-023 Reset SHALL override freeze.
REQ-024 The first edge after rst deasserts SHALL perform the normal priority action.
REQ-025 Reset asserted mid-stall or mid-count SHALL discard all held state.

Verification
REQ-026 Load: id_valid=1, WB_EN_in=1, Dest_in=4'h3, Val_Rn_in=32'hDEADBEEF, no controls -> one edge later WB_EN_out=1, Dest_out=3, Val_Rn_out=DEADBEEF, valid_out=1.
REQ-027 Hazard bubble: hazard=1 for 2 edges with MEM_W_EN_in=1 -> valid_out=0, MEM_W_EN_out=0 after each edge; bubble_cnt=2.
REQ-028 Freeze priority: freeze=1, flush=1, PC_out previously 32'h40 -> PC_out stays 32'h40, flush_cnt unchanged; freeze=0 with flush=1 still asserted -> next edge valid_out=0, flush_cnt +1.
REQ-029 Simultaneous flush+hazard, freeze=0, id_valid=1 -> flush_cnt +1, bubble_cnt unchanged, all control outputs 0.
REQ-030 Saturation: preload bubble_cnt to FFFF via 65535 hazard edges, apply one more hazard edge -> bubble_cnt stays 16'hFFFF.
REQ-031 Async reset: assert rst between clock edges while outputs are nonzero -> all outputs 0 before the next edge; outputs remain 0 while rst=1 with freeze=1.
